cw_tx_sequencer: RTL and testbench

//  Owns the transmitter T/R sequence for CW and voice. Arbitrates three key/PTT requesters:

---
 rtl/cw_seq_defs.sv | 29 ++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/cw_tx_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cw_tx_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cw_seq_defs.sv
// Shared definitions for the CW/voice transmit sequencer.
// Latency: n/a (types, constants and one elaboration-time helper).
// Backpressure: n/a.
package cw_seq_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_KEYED = 3'd2,
    ST_HANG  = 3'd3,
    ST_VOICE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_KEYER = 2'd1,
    OWN_HOST  = 2'd2,
    OWN_VOICE = 2'd3
  } owner_e;

  // Wide enough for both the 8-bit PTT lead and the 10-bit hang time.
  localparam int unsigned MS_CNT_W = 10;

  // Clock cycles per millisecond; clamps to 1 so slow clocks still tick.
  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return (clk_hz < 1000) ? 1 : clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every millisecond.
// Latency: tick asserted in the last cycle of each CLK_HZ/1000-cycle period.
// Backpressure: none; runs continuously once out of reset.
// Ports: clk_i/rst_i (sync active-high), tick_o one-cycle 1 ms strobe.
module ms_tick_gen
  import cw_seq_defs::*;
#(
  parameter int unsigned CLK_HZ = 48_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned DIV  = ms_div(CLK_HZ);
  localparam int unsigned CW   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cw_tx_sequencer.sv
// T/R sequencer: arbitrates keyer/host CW/voice PTT, PTT lead, hang time, stuck-key watchdog.
// Latency: registered outputs change on the edge entering a state; grant takes one edge.
// Backpressure: none; non-owner requests are simply ignored until the sequencer returns to IDLE.
// Ports: IF_clk/IF_rst (sync active-high); cw_enable, keyer_key, host_key, voice_ptt requests;
//   IF_CW_PTT_delay (ms), IF_CW_Hang_Time (ms); tx_ptt, tx_key, tx_owner, TxEN_start/TxEN_end
//   pulses, sticky key_timeout.
module cw_tx_sequencer
  import cw_seq_defs::*;
#(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned MAX_KEY_MS = 10_000
) (
  input  logic       IF_clk,
  input  logic       IF_rst,
  input  logic       cw_enable,
  input  logic       keyer_key,
  input  logic       host_key,
  input  logic       voice_ptt,
  input  logic [7:0] IF_CW_PTT_delay,
  input  logic [9:0] IF_CW_Hang_Time,
  output logic       tx_ptt,
  output logic       tx_key,
  output logic [1:0] tx_owner,
  output logic       TxEN_start,
  output logic       TxEN_end,
  output logic       key_timeout
);

  localparam int unsigned WD_W = (MAX_KEY_MS < 2) ? 1 : $clog2(MAX_KEY_MS + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_KEY_MS);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                ptt_q, ptt_d, key_q, key_d;
  logic                start_q, start_d, end_q, end_d;
  logic                timeout_q, timeout_d;
  logic                tick, own_req, cw_ok, wd_trip;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i (IF_clk),
    .rst_i (IF_rst),
    .tick_o(tick)
  );

  // Request of whoever holds the transmitter; dropping cw_enable reads as a CW key-up.
  always_comb begin
    own_req = 1'b0;
    case (owner_q)
      OWN_KEYER: own_req = cw_enable & keyer_key;
      OWN_HOST:  own_req = cw_enable & host_key;
      OWN_VOICE: own_req = voice_ptt;
      default:   own_req = 1'b0;
    endcase
  end

  assign cw_ok   = cw_enable & ~timeout_q;
  assign wd_trip = (MAX_KEY_MS != 0) && (wd_q >= WD_LIMIT);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ms_cnt_d  = ms_cnt_q;
    wd_d      = wd_q;
    ptt_d     = ptt_q;
    key_d     = key_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        ptt_d   = 1'b0;
        key_d   = 1'b0;
        owner_d = OWN_NONE;
        if (!keyer_key && !host_key && !voice_ptt) timeout_d = 1'b0;
        if (cw_ok && (keyer_key || host_key)) begin
          owner_d  = keyer_key ? OWN_KEYER : OWN_HOST;
          state_d  = ST_LEAD;
          ms_cnt_d = {2'b00, IF_CW_PTT_delay};
          ptt_d    = 1'b1;
          start_d  = 1'b1;
        end else if (voice_ptt) begin
          owner_d = OWN_VOICE;
          state_d = ST_VOICE;
          ptt_d   = 1'b1;
          start_d = 1'b1;
        end
      end
      ST_LEAD: begin
        if (ms_cnt_q == '0) begin
          if (own_req) begin
            state_d = ST_KEYED;
            key_d   = 1'b1;
            wd_d    = '0;
          end else begin
            state_d  = ST_HANG;
            ms_cnt_d = IF_CW_Hang_Time;
          end
        end else if (tick) begin
          ms_cnt_d = ms_cnt_q - 1'b1;
        end
      end
      ST_KEYED: begin
        // A genuine key-up wins over a simultaneous watchdog trip.
        if (!own_req || wd_trip) begin
          state_d  = ST_HANG;
          key_d    = 1'b0;
          ms_cnt_d = IF_CW_Hang_Time;
          if (own_req) timeout_d = 1'b1;
        end else if (tick && (wd_q != '1)) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_HANG: begin
        // Re-key inside the hang window returns straight to carrier; relay is already settled.
        if (own_req && !timeout_q) begin
          state_d = ST_KEYED;
          key_d   = 1'b1;
          wd_d    = '0;
        end else if (ms_cnt_q == '0) begin
          state_d = ST_IDLE;
          ptt_d   = 1'b0;
          owner_d = OWN_NONE;
          end_d   = 1'b1;
        end else if (tick) begin
          ms_cnt_d = ms_cnt_q - 1'b1;
        end
      end
      ST_VOICE: begin
        if (!voice_ptt) begin
          state_d = ST_IDLE;
          ptt_d   = 1'b0;
          owner_d = OWN_NONE;
          end_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptt_d   = 1'b0;
        key_d   = 1'b0;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge IF_clk) begin
    if (IF_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      ms_cnt_q  <= '0;
      wd_q      <= '0;
      ptt_q     <= 1'b0;
      key_q     <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ms_cnt_q  <= ms_cnt_d;
      wd_q      <= wd_d;
      ptt_q     <= ptt_d;
      key_q     <= key_d;
      start_q   <= start_d;
      end_q     <= end_d;
      timeout_q <= timeout_d;
    end
  end

  assign tx_ptt      = ptt_q;
  assign tx_key      = key_q;
  assign tx_owner    = owner_q;
  assign TxEN_start  = start_q;
  assign TxEN_end    = end_q;
  assign key_timeout = timeout_q;

endmodule

// File: tb/tb_cw_tx_sequencer.sv
// Bench for cw_tx_sequencer at 10 cycles per ms with a 50 ms carrier limit.
// Expected edge times come from ms-level rules: an N ms interval lasts N*10 cycles,
// up to one tick period early (plus one cycle for the state exit); 0 ms lasts one cycle.
module tb_cw_tx_sequencer;

  localparam int CPM   = 10;
  localparam int MAXMS = 50;

  logic       IF_clk = 1'b0;
  logic       IF_rst = 1'b1;
  logic       cw_enable = 1'b0, keyer_key = 1'b0, host_key = 1'b0, voice_ptt = 1'b0;
  logic [7:0] dly = 8'd0;
  logic [9:0] hang = 10'd0;
  logic       tx_ptt, tx_key, TxEN_start, TxEN_end, key_timeout;
  logic [1:0] tx_owner;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Event recorder: last edge times and cumulative pulse counts.
  int         t_ptt_up = -1, t_ptt_dn = -1, t_key_up = -1, t_key_dn = -1;
  int         n_start = 0, n_end = 0, n_key_up = 0;
  logic [1:0] own_up = 2'd0;
  logic       p_ptt = 1'b0, p_key = 1'b0;

  cw_tx_sequencer #(.CLK_HZ(10_000), .MAX_KEY_MS(MAXMS)) dut (
    .IF_clk(IF_clk), .IF_rst(IF_rst), .cw_enable(cw_enable), .keyer_key(keyer_key),
    .host_key(host_key), .voice_ptt(voice_ptt), .IF_CW_PTT_delay(dly),
    .IF_CW_Hang_Time(hang), .tx_ptt(tx_ptt), .tx_key(tx_key), .tx_owner(tx_owner),
    .TxEN_start(TxEN_start), .TxEN_end(TxEN_end), .key_timeout(key_timeout)
  );

  always #5 IF_clk = ~IF_clk;
  always @(posedge IF_clk) cyc <= cyc + 1;

  always @(negedge IF_clk) begin
    if (tx_ptt && !p_ptt) begin t_ptt_up = cyc; own_up = tx_owner; end
    if (!tx_ptt && p_ptt) t_ptt_dn = cyc;
    if (tx_key && !p_key) begin t_key_up = cyc; n_key_up++; end
    if (!tx_key && p_key) t_key_dn = cyc;
    if (TxEN_start) n_start++;
    if (TxEN_end) n_end++;
    p_ptt = tx_ptt;
    p_key = tx_key;
  end

  function automatic int win_lo(input int ms);
    return (ms == 0) ? 1 : ms * CPM - 9;
  endfunction
  function automatic int win_hi(input int ms);
    return (ms == 0) ? 1 : ms * CPM + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge IF_clk); #2; end
  endtask

  task automatic wait_ptt_dn(input int after, output bit ok);
    int b;
    b = 0;
    ok = 1'b0;
    while (b < 3000 && !ok) begin
      step(1);
      b++;
      if (t_ptt_dn > after) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    IF_rst = 1'b1;
    step(3);
    n_cmp++; if (tx_ptt !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ptt: got %0d expected 0", tx_ptt); end
    n_cmp++; if (tx_key !== 1'b0) begin n_bad++; $display("FAIL reset_tx_key: got %0d expected 0", tx_key); end
    n_cmp++; if (tx_owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d expected 0", tx_owner); end
    n_cmp++; if ({TxEN_start, TxEN_end} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b expected 00", {TxEN_start, TxEN_end}); end
    n_cmp++; if (key_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %0d expected 0", key_timeout); end
    IF_rst = 1'b0;
    cw_enable = 1'b1;
    step(5);
    n_cmp++; if (tx_ptt !== 1'b0) begin n_bad++; $display("FAIL idle_no_request: tx_ptt got %0d expected 0", tx_ptt); end
  endtask

  // One keyer pulse of p ms with lead d ms and hang h ms.
  task automatic test_keyer_sequence(input int d, input int h, input int p);
    int s0, e0, ku0, n0, n1, lead, hg;
    bit ok;
    dly = 8'(d); hang = 10'(h);
    s0 = n_start; e0 = n_end; ku0 = n_key_up;
    n0 = cyc; keyer_key = 1'b1;
    step(p * CPM);
    n1 = cyc; keyer_key = 1'b0;
    wait_ptt_dn(n1, ok);
    lead = t_key_up - t_ptt_up;
    hg = t_ptt_dn - t_key_dn;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_ptt_drop d=%0d h=%0d: tx_ptt still %0d expected 0", d, h, tx_ptt); end
    n_cmp++; if (t_ptt_up !== n0 + 1) begin n_bad++; $display("FAIL seq_ptt_rise d=%0d: got cycle %0d expected %0d", d, t_ptt_up, n0 + 1); end
    n_cmp++; if (own_up !== 2'd1) begin n_bad++; $display("FAIL seq_owner: got %0d expected 1", own_up); end
    n_cmp++; if (lead < win_lo(d) || lead > win_hi(d)) begin n_bad++; $display("FAIL seq_lead d=%0d: got %0d cycles expected %0d..%0d", d, lead, win_lo(d), win_hi(d)); end
    n_cmp++; if (t_key_dn !== n1 + 1) begin n_bad++; $display("FAIL seq_key_drop: got cycle %0d expected %0d", t_key_dn, n1 + 1); end
    n_cmp++; if (hg < win_lo(h) || hg > win_hi(h)) begin n_bad++; $display("FAIL seq_hang h=%0d: got %0d cycles expected %0d..%0d", h, hg, win_lo(h), win_hi(h)); end
    n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL seq_start_pulses: got %0d expected 1", n_start - s0); end
    n_cmp++; if (n_end - e0 !== 1) begin n_bad++; $display("FAIL seq_end_pulses: got %0d expected 1", n_end - e0); end
    n_cmp++; if (n_key_up - ku0 !== 1) begin n_bad++; $display("FAIL seq_key_rises: got %0d expected 1", n_key_up - ku0); end
    step(5);
  endtask

  task automatic test_basic();
    test_keyer_sequence(5, 8, 20);
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'($urandom_range(0, 12));
      test_keyer_sequence(d, int'($urandom_range(0, 12)), d + int'($urandom_range(3, 15)));
    end
  endtask

  task automatic test_priority();
    int s0, e0, ku0, n1, n2, x;
    logic [1:0] o1;
    bit ok, ok2;
    dly = 8'd2; hang = 10'd2;
    s0 = n_start; e0 = n_end; ku0 = n_key_up;
    keyer_key = 1'b1; host_key = 1'b1;
    step(2);
    o1 = own_up;
    step(8 * CPM - 2);
    n1 = cyc; keyer_key = 1'b0;
    wait_ptt_dn(n1, ok);
    x = t_ptt_dn;
    step(3);
    n_cmp++; if (o1 !== 2'd1) begin n_bad++; $display("FAIL prio_owner: got %0d expected 1", o1); end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL prio_ptt_drop: tx_ptt still %0d expected 0", tx_ptt); end
    n_cmp++; if (t_key_dn !== n1 + 1) begin n_bad++; $display("FAIL prio_host_ignored: key drop cycle %0d expected %0d", t_key_dn, n1 + 1); end
    n_cmp++; if (t_ptt_up !== x + 1 || own_up !== 2'd2) begin n_bad++; $display("FAIL prio_host_regrant: rise %0d owner %0d expected %0d owner 2", t_ptt_up, own_up, x + 1); end
    n2 = cyc; host_key = 1'b0;
    wait_ptt_dn(n2, ok2);
    n_cmp++; if (!ok2) begin n_bad++; $display("FAIL prio_host_release: tx_ptt still %0d expected 0", tx_ptt); end
    n_cmp++; if (n_key_up - ku0 !== 1) begin n_bad++; $display("FAIL prio_key_rises: got %0d expected 1", n_key_up - ku0); end
    n_cmp++; if (n_start - s0 !== 2 || n_end - e0 !== 2) begin n_bad++; $display("FAIL prio_pulses: start %0d end %0d expected 2 2", n_start - s0, n_end - e0); end
    step(5);
  endtask

  task automatic test_rekey();
    int s0, e0, ku0, n2, n3, g, hg;
    bit ok;
    dly = 8'd3; hang = 10'd8;
    g = int'($urandom_range(1, 6));
    s0 = n_start; e0 = n_end; ku0 = n_key_up;
    keyer_key = 1'b1; step(10 * CPM);
    keyer_key = 1'b0; step(g * CPM);
    n2 = cyc; keyer_key = 1'b1; step(5 * CPM);
    n3 = cyc; keyer_key = 1'b0;
    wait_ptt_dn(n3, ok);
    hg = t_ptt_dn - t_key_dn;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rekey_ptt_drop: tx_ptt still %0d expected 0", tx_ptt); end
    n_cmp++; if (t_key_up !== n2 + 1) begin n_bad++; $display("FAIL rekey_no_lead gap=%0d: key rise %0d expected %0d", g, t_key_up, n2 + 1); end
    n_cmp++; if (t_key_dn !== n3 + 1) begin n_bad++; $display("FAIL rekey_key_drop: got %0d expected %0d", t_key_dn, n3 + 1); end
    n_cmp++; if (hg < win_lo(8) || hg > win_hi(8)) begin n_bad++; $display("FAIL rekey_hang: got %0d cycles expected %0d..%0d", hg, win_lo(8), win_hi(8)); end
    n_cmp++; if (n_start - s0 !== 1 || n_end - e0 !== 1) begin n_bad++; $display("FAIL rekey_pulses: start %0d end %0d expected 1 1", n_start - s0, n_end - e0); end
    n_cmp++; if (n_key_up - ku0 !== 2) begin n_bad++; $display("FAIL rekey_key_rises: got %0d expected 2", n_key_up - ku0); end
    step(5);
  endtask

  task automatic test_watchdog();
    int s0, e0, ku0, kd, hg;
    dly = 8'd2; hang = 10'd3;
    s0 = n_start; e0 = n_end; ku0 = n_key_up;
    keyer_key = 1'b1;
    step(80 * CPM);
    kd = t_key_dn - t_key_up;
    hg = t_ptt_dn - t_key_dn;
    n_cmp++; if (kd < win_lo(MAXMS) || kd > win_hi(MAXMS)) begin n_bad++; $display("FAIL wd_carrier_len: got %0d cycles expected %0d..%0d", kd, win_lo(MAXMS), win_hi(MAXMS)); end
    n_cmp++; if (key_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_flag_set: got %0d expected 1", key_timeout); end
    n_cmp++; if (n_key_up - ku0 !== 1) begin n_bad++; $display("FAIL wd_no_rekey: key rises %0d expected 1", n_key_up - ku0); end
    n_cmp++; if (hg < win_lo(3) || hg > win_hi(3)) begin n_bad++; $display("FAIL wd_hang: got %0d cycles expected %0d..%0d", hg, win_lo(3), win_hi(3)); end
    n_cmp++; if (tx_ptt !== 1'b0 || n_start - s0 !== 1 || n_end - e0 !== 1) begin n_bad++; $display("FAIL wd_idle_held: ptt %0d start %0d end %0d expected 0 1 1", tx_ptt, n_start - s0, n_end - e0); end
    keyer_key = 1'b0;
    step(3);
    n_cmp++; if (key_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_flag_clear: got %0d expected 0", key_timeout); end
    step(3);
  endtask

  task automatic test_voice();
    int s0, e0, ku0, n0, n1;
    s0 = n_start; e0 = n_end; ku0 = n_key_up;
    cw_enable = 1'b0;
    n0 = cyc; keyer_key = 1'b1; voice_ptt = 1'b1;
    step(5 * CPM);
    n1 = cyc; voice_ptt = 1'b0;
    step(3);
    keyer_key = 1'b0;
    n_cmp++; if (t_ptt_up !== n0 + 1 || own_up !== 2'd3) begin n_bad++; $display("FAIL voice_grant: rise %0d owner %0d expected %0d owner 3", t_ptt_up, own_up, n0 + 1); end
    n_cmp++; if (t_ptt_dn !== n1 + 1) begin n_bad++; $display("FAIL voice_no_hang: drop %0d expected %0d", t_ptt_dn, n1 + 1); end
    n_cmp++; if (n_key_up - ku0 !== 0) begin n_bad++; $display("FAIL voice_no_carrier: key rises %0d expected 0", n_key_up - ku0); end
    n_cmp++; if (n_start - s0 !== 1 || n_end - e0 !== 1) begin n_bad++; $display("FAIL voice_pulses: start %0d end %0d expected 1 1", n_start - s0, n_end - e0); end
    cw_enable = 1'b1;
    step(3);
  endtask

  task automatic test_reset_keyed();
    int e0;
    dly = 8'd1; hang = 10'd5;
    e0 = n_end;
    keyer_key = 1'b1;
    step(3 * CPM);
    n_cmp++; if (tx_key !== 1'b1) begin n_bad++; $display("FAIL rst_pre_keyed: tx_key %0d expected 1", tx_key); end
    IF_rst = 1'b1;
    step(1);
    n_cmp++; if ({tx_ptt, tx_key, tx_owner, TxEN_end} !== 5'b0) begin n_bad++; $display("FAIL rst_mid_tx: ptt %0d key %0d owner %0d end %0d expected all 0", tx_ptt, tx_key, tx_owner, TxEN_end); end
    IF_rst = 1'b0; keyer_key = 1'b0;
    step(5);
    n_cmp++; if (n_end - e0 !== 0 || tx_ptt !== 1'b0) begin n_bad++; $display("FAIL rst_no_end_pulse: end pulses %0d ptt %0d expected 0 0", n_end - e0, tx_ptt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_rekey();
    test_watchdog();
    test_keyer_sequence(0, 0, 3);
    test_voice();
    test_reset_keyed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
